// File: rtl/video_timing.sv
// Raster timing generator: x/y counters, sync/de decode, LAT-stage pipeline and output register.
// Outputs trail x/y by LAT+1 en-ticks; en=0 freezes all state.
module video_timing #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   LAT      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } tim_t;

  tim_t raw;
  tim_t dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == H_LAST) begin
        x <= '0;
        y <= (y == V_LAST) ? '0 : y + 10'd1;
      end else begin
        x <= x + 11'd1;
      end
    end
  end

  // Sync flags are kept active-high internally; polarity is applied at the output register.
  always_comb begin
    raw    = '0;
    raw.de = (x < H_ACT) && (y < V_ACT);
    raw.hs = (x >= HS_START) && (x < HS_END);
    raw.vs = (y >= VS_START) && (y < VS_END);
    raw.fs = (x == 11'd0) && (y == 10'd0);
  end

  generate
    if (LAT == 0) begin : g_bypass
      assign dly = raw;
    end else begin : g_pipe
      tim_t pipe [LAT];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (en) begin
          pipe[0] <= raw;
          for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dly = pipe[LAT-1];
    end
  endgenerate

  // Colour is forced to black outside the visible area so r_in/g_in/b_in are don't-care there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de          <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
    end else if (en) begin
      de          <= dly.de;
      frame_start <= dly.fs;
      hsync       <= dly.hs ? HS_POL : ~HS_POL;
      vsync       <= dly.vs ? VS_POL : ~VS_POL;
      r_out       <= dly.de ? r_in : 8'd0;
      g_out       <= dly.de ? g_in : 8'd0;
      b_out       <= dly.de ? b_in : 8'd0;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: default-geometry table checks (LAT=0 and LAT=3) plus a
// small-geometry instance under random en/colour checked against a tick-count model.
module tb_video_timing;

  logic clk;
  logic rst_d, rst_s;
  logic en_d, en_s;

  int total = 0;
  int bad   = 0;

  // default geometry, LAT=0
  logic [7:0]  rgb0;
  logic [10:0] x0;
  logic [9:0]  y0;
  logic        hs0, vs0, de0, fs0;
  logic [7:0]  r0, g0, b0;

  // default geometry, LAT=3, colour = x[7:0] through a 3-tick bench delay
  logic [7:0]  d1, d2, d3;
  logic [10:0] x3;
  logic [9:0]  y3;
  logic        hs3, vs3, de3, fs3;
  logic [7:0]  r3, g3, b3;

  // small geometry: 13 x 8, LAT=2, HS_POL=0, VS_POL=1
  localparam int SH = 13;
  localparam int SV = 8;
  localparam int SF = SH * SV;
  localparam int SL = 2;
  logic [7:0]  ri_s, gi_s, bi_s;
  logic [10:0] x_s;
  logic [9:0]  y_s;
  logic        hs_s, vs_s, de_s, fs_s;
  logic [7:0]  ro_s, go_s, bo_s;

  video_timing u0 (
    .clk(clk), .reset(rst_d), .en(en_d),
    .r_in(rgb0), .g_in(rgb0), .b_in(rgb0),
    .x(x0), .y(y0), .hsync(hs0), .vsync(vs0), .de(de0),
    .r_out(r0), .g_out(g0), .b_out(b0), .frame_start(fs0)
  );

  video_timing #(.LAT(3)) u3 (
    .clk(clk), .reset(rst_d), .en(en_d),
    .r_in(d3), .g_in(d3), .b_in(d3),
    .x(x3), .y(y3), .hsync(hs3), .vsync(vs3), .de(de3),
    .r_out(r3), .g_out(g3), .b_out(b3), .frame_start(fs3)
  );

  video_timing #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .LAT(SL)
  ) us (
    .clk(clk), .reset(rst_s), .en(en_s),
    .r_in(ri_s), .g_in(gi_s), .b_in(bi_s),
    .x(x_s), .y(y_s), .hsync(hs_s), .vsync(vs_s), .de(de_s),
    .r_out(ro_s), .g_out(go_s), .b_out(bo_s), .frame_start(fs_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for an anti-aliasing stage with 3 ticks of latency.
  always @(posedge clk or posedge rst_d) begin
    if (rst_d) begin
      d1 <= 8'd0;
      d2 <= 8'd0;
      d3 <= 8'd0;
    end else if (en_d) begin
      d1 <= x3[7:0];
      d2 <= d1;
      d3 <= d2;
    end
  end

  // Reference for the small instance: count en-ticks; the output reflects raster
  // position (ticks - 1 - LAT) taken modulo the frame size.
  int   m_n;
  bit   m_de, m_hs, m_vs, m_fs;
  logic [7:0] m_r, m_g, m_b;

  always @(posedge clk or posedge rst_s) begin
    int k, p, px, py;
    if (rst_s) begin
      m_n = 0; m_de = 0; m_hs = 1; m_vs = 0; m_fs = 0;
      m_r = 0; m_g = 0; m_b = 0;
    end else if (en_s) begin
      m_n = m_n + 1;
      k = m_n - 1 - SL;
      if (k < 0) begin
        m_de = 0; m_hs = 1; m_vs = 0; m_fs = 0;
      end else begin
        p  = k % SF;
        px = p % SH;
        py = p / SH;
        m_de = (px < 6) && (py < 4);
        m_hs = !((px >= 8) && (px < 11));
        m_vs = (py >= 5) && (py < 7);
        m_fs = (p == 0);
      end
      m_r = m_de ? ri_s : 8'd0;
      m_g = m_de ? gi_s : 8'd0;
      m_b = m_de ? bi_s : 8'd0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [10:0] ex;
    logic [9:0]  ey;
    ex = 11'(m_n % SH);
    ey = 10'((m_n / SH) % SV);
    total++;
    if ({x_s, y_s, de_s, hs_s, vs_s, fs_s, ro_s, go_s, bo_s} !==
        {ex, ey, m_de, m_hs, m_vs, m_fs, m_r, m_g, m_b}) begin
      bad++;
      $display("FAIL model t=%0t got x=%0d y=%0d de=%b hs=%b vs=%b fs=%b rgb=%h%h%h want x=%0d y=%0d de=%b hs=%b vs=%b fs=%b rgb=%h%h%h",
               $time, x_s, y_s, de_s, hs_s, vs_s, fs_s, ro_s, go_s, bo_s,
               ex, ey, m_de, m_hs, m_vs, m_fs, m_r, m_g, m_b);
    end
  endtask

  typedef struct {
    int n; int x; int y; bit de; bit fs; bit hs; bit de3; bit hs3; int r3;
  } row_t;

  row_t tbl [18];

  initial begin
    int ri, cnt0, first0, last0, cnt3, first3, last3;
    int fcount, fs_first, fs_second, decount, leak;

    //        n     x     y  de fs hs de3 hs3 r3
    tbl = '{'{   0,    0, 0, 0, 0, 0, 0, 0,   0},
            '{   1,    1, 0, 1, 1, 0, 0, 0,   0},
            '{   2,    2, 0, 1, 0, 0, 0, 0,   0},
            '{   4,    4, 0, 1, 0, 0, 1, 0,   0},
            '{   5,    5, 0, 1, 0, 0, 1, 0,   1},
            '{ 259,  259, 0, 1, 0, 0, 1, 0, 255},
            '{ 260,  260, 0, 1, 0, 0, 1, 0,   0},
            '{1280, 1280, 0, 1, 0, 0, 1, 0, 252},
            '{1281, 1281, 0, 0, 0, 0, 1, 0, 253},
            '{1285, 1285, 0, 0, 0, 0, 0, 0,   0},
            '{1391, 1391, 0, 0, 0, 1, 0, 0,   0},
            '{1394, 1394, 0, 0, 0, 1, 0, 1,   0},
            '{1430, 1430, 0, 0, 0, 1, 0, 1,   0},
            '{1431, 1431, 0, 0, 0, 0, 0, 1,   0},
            '{1434, 1434, 0, 0, 0, 0, 0, 0,   0},
            '{1650,    0, 1, 0, 0, 0, 0, 0,   0},
            '{1651,    1, 1, 1, 0, 0, 0, 0,   0},
            '{1655,    5, 1, 1, 0, 0, 1, 0,   1}};

    rst_d = 1; rst_s = 1; en_d = 1; en_s = 1;
    rgb0 = 8'hA5; ri_s = 8'h11; gi_s = 8'h22; bi_s = 8'h33;
    repeat (3) @(negedge clk);

    // reset values held despite en=1 and running clock
    chk("rst_x0", x0, 0);
    chk("rst_hs0", hs0, 0);
    chk("rst_vs0", vs0, 0);
    chk("rst_r3", r3, 0);
    chk("rst_xs", x_s, 0);
    chk("rst_hss", hs_s, 1);
    chk("rst_des", de_s, 0);

    // default geometry, first line and a bit
    rst_d = 0;
    ri = 0; cnt0 = 0; first0 = -1; last0 = -1; cnt3 = 0; first3 = -1; last3 = -1;
    for (int n = 0; n <= 1660; n++) begin
      if (ri < 18 && tbl[ri].n == n) begin
        chk($sformatf("x0@%0d", n),  x0,  tbl[ri].x);
        chk($sformatf("y0@%0d", n),  y0,  tbl[ri].y);
        chk($sformatf("de0@%0d", n), de0, 32'(tbl[ri].de));
        chk($sformatf("fs0@%0d", n), fs0, 32'(tbl[ri].fs));
        chk($sformatf("hs0@%0d", n), hs0, 32'(tbl[ri].hs));
        chk($sformatf("r0@%0d", n),  r0,  tbl[ri].de ? 32'hA5 : 32'h0);
        chk($sformatf("de3@%0d", n), de3, 32'(tbl[ri].de3));
        chk($sformatf("hs3@%0d", n), hs3, 32'(tbl[ri].hs3));
        chk($sformatf("r3@%0d", n),  r3,  tbl[ri].r3);
        ri++;
      end
      if (hs0) begin cnt0++; if (first0 < 0) first0 = n; last0 = n; end
      if (hs3) begin cnt3++; if (first3 < 0) first3 = n; last3 = n; end
      @(negedge clk);
    end
    chk("hs0_width", cnt0, 40);
    chk("hs0_first", first0, 1391);
    chk("hs0_last", last0, 1430);
    chk("hs3_width", cnt3, 40);
    chk("hs3_first", first3, 1394);
    chk("hs3_last", last3, 1433);

    // en toggling 1,0,1,0 on the small instance
    rst_s = 0;
    en_s = 1; @(negedge clk); chk("tog_x1", x_s, 1); cmp_model();
    en_s = 0; @(negedge clk); chk("tog_x2", x_s, 1); cmp_model();
    en_s = 1; @(negedge clk); chk("tog_x3", x_s, 2); cmp_model();
    en_s = 0; @(negedge clk); chk("tog_x4", x_s, 2); cmp_model();

    // random en and colour, with a two-clock mid-frame reset
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        rst_s = 1;
        #1;
        chk("mid_rst_x", x_s, 0);
        chk("mid_rst_y", y_s, 0);
        chk("mid_rst_de", de_s, 0);
        chk("mid_rst_hs", hs_s, 1);
        chk("mid_rst_rgb", {ro_s, go_s, bo_s}, 0);
      end
      if (i == 1202) rst_s = 0;
      en_s = ($urandom_range(0, 3) != 0);
      ri_s = 8'($urandom);
      gi_s = 8'($urandom);
      bi_s = 8'($urandom);
      @(negedge clk);
      cmp_model();
    end

    // constant white input over three frames
    rst_s = 1;
    @(negedge clk);
    rst_s = 0; en_s = 1; ri_s = 8'hFF; gi_s = 8'hFF; bi_s = 8'hFF;
    fcount = 0; fs_first = -1; fs_second = -1; decount = 0; leak = 0;
    for (int n = 1; n <= 3 * SF; n++) begin
      @(negedge clk);
      cmp_model();
      if (fs_s) begin
        fcount++;
        if (fs_first < 0) fs_first = n;
        else if (fs_second < 0) fs_second = n;
      end
      if (de_s && ro_s == 8'hFF && go_s == 8'hFF && bo_s == 8'hFF) decount++;
      if (!de_s && {ro_s, go_s, bo_s} != 24'h0) leak++;
    end
    chk("fs_count", fcount, 3);
    chk("fs_first", fs_first, 3);
    chk("fs_period", fs_second - fs_first, SF);
    chk("white_pixels", decount, 72);
    chk("blank_leak", leak, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
